interleaved_modmult: RTL and testbench

Bit-serial modular multiplier. It computes result = (a * b) mod n using the interleaved shift-add-reduce method.
It is the responder side of the go/done multiply handshake that the exponentiation controller drives; the RSA datapath uses it as its multiply engine.
Operands are latched on go. The engine processes one multiplier bit per cycle and pulses done with a held result.

---
 rtl/rsa_pkg.sv | 16 +
 rtl/modmult_step.sv | 28 ++
 rtl/interleaved_modmult.sv | 153 +++++++++++++++
 tb/tb_interleaved_modmult.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA datapath engines.
package rsa_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } modmult_state_t;

  localparam int RSA_WIDTH = 32;

  // Bit-counter width; wide enough to hold WIDTH-1.
  function automatic int modmult_cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/modmult_step.sv
// One interleaved shift-add-reduce iteration: P' = (2P + bit*b) mod n, given P < n.
module modmult_step
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic [WIDTH+1:0] p_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH+1:0] p_out
);

  logic [WIDTH+1:0] b_ext;
  logic [WIDTH+1:0] n_ext;
  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] red1;

  // 2P + b < 3n, so two conditional subtractions always restore P < n.
  always_comb begin
    b_ext = {2'b00, b};
    n_ext = {2'b00, n};
    sum   = (p_in << 1) + (bit_in ? b_ext : '0);
    red1  = (sum >= n_ext) ? (sum - n_ext) : sum;
    p_out = (red1 >= n_ext) ? (red1 - n_ext) : red1;
  end

endmodule

// File: rtl/interleaved_modmult.sv
// Bit-serial (a*b) mod n engine, MSB-first interleaved reduction with a go/done handshake.
// Define MODMULT_RADIX4_EN to process two multiplier bits per cycle (WIDTH must be even).
module interleaved_modmult
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam int CW = modmult_cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  if (WIDTH < 2) begin : g_bad_width
    $fatal(1, "interleaved_modmult: WIDTH must be at least 2");
  end

  modmult_state_t   state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH+1:0] p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH+1:0] p_step0;
  logic [WIDTH+1:0] p_next;
  logic [CW-1:0]    cnt_step;
  logic             last_iter;
  logic             bad_operands;

  modmult_step #(.WIDTH(WIDTH)) u_step0 (
    .p_in  (p_q),
    .bit_in(a_q[cnt_q]),
    .b     (b_q),
    .n     (n_q),
    .p_out (p_step0)
  );

`ifdef MODMULT_RADIX4_EN
  if ((WIDTH % 2) != 0) begin : g_odd_width
    $fatal(1, "interleaved_modmult: radix-4 mode requires an even WIDTH");
  end

  logic [CW-1:0] cnt_lo;
  assign cnt_lo = cnt_q - 1'b1;

  // Second iteration consumes bit i-1 in the same cycle.
  modmult_step #(.WIDTH(WIDTH)) u_step1 (
    .p_in  (p_step0),
    .bit_in(a_q[cnt_lo]),
    .b     (b_q),
    .n     (n_q),
    .p_out (p_next)
  );

  assign cnt_step  = CW'(2);
  assign last_iter = (cnt_q == CW'(1));
`else
  assign p_next    = p_step0;
  assign cnt_step  = CW'(1);
  assign last_iter = (cnt_q == '0);
`endif

  assign bad_operands = (n == '0) || (a >= n) || (b >= n);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          a_d   = a;
          b_d   = b;
          n_d   = n;
          p_d   = '0;
          cnt_d = CNT_TOP;
          err_d = 1'b0;
          // Faulty operands complete at once with a zero result and err set.
          if (bad_operands) begin
            result_d = '0;
            err_d    = 1'b1;
            done_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        p_d   = p_next;
        cnt_d = cnt_q - cnt_step;
        if (last_iter) begin
          result_d = p_next[WIDTH-1:0];
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = (state_q == CALC);
  assign err    = err_q;

endmodule

// File: tb/tb_interleaved_modmult.sv
// Scoreboard bench for interleaved_modmult at WIDTH=8 and WIDTH=32.
// Honours MODMULT_RADIX4_EN for the expected latency.
module tb_interleaved_modmult;

`ifdef MODMULT_RADIX4_EN
  localparam int LAT8  = 4;
  localparam int LAT32 = 16;
`else
  localparam int LAT8  = 8;
  localparam int LAT32 = 32;
`endif

  typedef struct {
    logic [63:0] res;
    logic        err;
    int          edges;
    int          busy_cycles;
    int          issue_cyc;
    int          busy_start;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, n8 = '0;
  logic [7:0]  result8;
  logic        done8, busy8, err8;
  logic        go32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, n32 = '0;
  logic [31:0] result32;
  logic        done32, busy32, err32;

  exp_t q8[$];
  exp_t q32[$];
  int   cyc = 0;
  int   busy_tot8 = 0;
  int   busy_tot32 = 0;
  int   vectors_applied = 0;
  int   miscompares = 0;

  interleaved_modmult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .go(go8), .a(a8), .b(b8), .n(n8),
    .result(result8), .done(done8), .busy(busy8), .err(err8)
  );

  interleaved_modmult #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .go(go32), .a(a32), .b(b32), .n(n32),
    .result(result32), .done(done32), .busy(busy32), .err(err32)
  );

  always #5 clk = ~clk;

  // Edge counter and busy-cycle totals; busy is sampled as it was before each edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (busy8)  busy_tot8  <= busy_tot8 + 1;
    if (busy32) busy_tot32 <= busy_tot32 + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] n, input int lat);
    exp_t e;
    e.issue_cyc  = 0;
    e.busy_start = 0;
    if (n == 0 || a >= n || b >= n) begin
      e.res = '0; e.err = 1'b1; e.edges = 0; e.busy_cycles = 0;
    end else begin
      e.res = (a * b) % n; e.err = 1'b0; e.edges = lat; e.busy_cycles = lat;
    end
    return e;
  endfunction

  // "edges" counts clock edges from the go-sampling edge to the one raising done.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) checkOutput("w8_spurious_done", 64'd1, 64'd0);
      else begin
        e = q8.pop_front();
        checkOutput("w8_result", {56'd0, result8}, e.res);
        checkOutput("w8_err", {63'd0, err8}, {63'd0, e.err});
        checkOutput("w8_latency", 64'(cyc - e.issue_cyc), 64'(e.edges));
        checkOutput("w8_busy_cycles", 64'(busy_tot8 - e.busy_start), 64'(e.busy_cycles));
      end
    end
  end

  always @(negedge clk) begin : mon32
    exp_t e;
    if (done32) begin
      if (q32.size() == 0) checkOutput("w32_spurious_done", 64'd1, 64'd0);
      else begin
        e = q32.pop_front();
        checkOutput("w32_result", {32'd0, result32}, e.res);
        checkOutput("w32_err", {63'd0, err32}, {63'd0, e.err});
        checkOutput("w32_latency", 64'(cyc - e.issue_cyc), 64'(e.edges));
        checkOutput("w32_busy_cycles", 64'(busy_tot32 - e.busy_start), 64'(e.busy_cycles));
      end
    end
  end

  task automatic waitDrain8(input int budget);
    for (int k = 0; k < budget && q8.size() != 0; k++) @(negedge clk);
    if (q8.size() != 0) begin
      checkOutput("w8_timeout_pending", 64'(q8.size()), 64'd0);
      q8.delete();
    end
  endtask

  task automatic waitDrain32(input int budget);
    for (int k = 0; k < budget && q32.size() != 0; k++) @(negedge clk);
    if (q32.size() != 0) begin
      checkOutput("w32_timeout_pending", 64'(q32.size()), 64'd0);
      q32.delete();
    end
  endtask

  // One-cycle go; inputs are scrambled right after acceptance to prove they were latched.
  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n);
    exp_t e;
    @(negedge clk);
    a8 = a; b8 = b; n8 = n; go8 = 1'b1;
    @(posedge clk);
    #1;
    e = model({56'd0, a}, {56'd0, b}, {56'd0, n}, LAT8);
    e.issue_cyc  = cyc;
    e.busy_start = busy_tot8;
    q8.push_back(e);
    go8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); n8 = 8'($urandom);
    waitDrain8(LAT8 + 6);
  endtask

  task automatic applyStimulus32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n);
    exp_t e;
    @(negedge clk);
    a32 = a; b32 = b; n32 = n; go32 = 1'b1;
    @(posedge clk);
    #1;
    e = model({32'd0, a}, {32'd0, b}, {32'd0, n}, LAT32);
    e.issue_cyc  = cyc;
    e.busy_start = busy_tot32;
    q32.push_back(e);
    go32 = 1'b0;
    a32 = $urandom; b32 = $urandom; n32 = $urandom;
    waitDrain32(LAT32 + 6);
  endtask

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog: got=no_finish expected=finish_before_3ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    logic        accept;
    logic [7:0]  ra, rb, rn;
    logic [31:0] xa, xb, xn;

    #3;
    checkOutput("reset_result8", {56'd0, result8}, 64'd0);
    checkOutput("reset_done8", {63'd0, done8}, 64'd0);
    checkOutput("reset_busy8", {63'd0, busy8}, 64'd0);
    checkOutput("reset_err8", {63'd0, err8}, 64'd0);
    checkOutput("reset_result32", {32'd0, result32}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed WIDTH=8 cases, including boundaries and operand faults.
    applyStimulus8(8'd7, 8'd9, 8'd13);
    applyStimulus8(8'd12, 8'd12, 8'd13);
    applyStimulus8(8'd0, 8'd5, 8'd13);
    applyStimulus8(8'd250, 8'd250, 8'd251);
    applyStimulus8(8'd254, 8'd254, 8'd255);
    applyStimulus8(8'd0, 8'd0, 8'd1);
    applyStimulus8(8'd3, 8'd4, 8'd0);
    applyStimulus8(8'd20, 8'd3, 8'd13);
    applyStimulus8(8'd3, 8'd13, 8'd13);
    applyStimulus8(8'd7, 8'd9, 8'd13);

    // Held go: engine restarts each time it returns to IDLE, including the done cycle.
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd6; n8 = 8'd7; go8 = 1'b1;
    for (int k = 0; k < 30; k++) begin
      accept = !busy8;
      @(posedge clk);
      #1;
      if (accept) begin
        exp_t e;
        e = model(64'd5, 64'd6, 64'd7, LAT8);
        e.issue_cyc  = cyc;
        e.busy_start = busy_tot8;
        q8.push_back(e);
      end
      @(negedge clk);
    end
    go8 = 1'b0;
    waitDrain8(2 * (LAT8 + 6));

    // Reset mid-CALC: outputs clear immediately, no done, then a clean restart.
    applyStimulus8(8'd20, 8'd3, 8'd13);
    @(negedge clk);
    a8 = 8'd7; b8 = 8'd9; n8 = 8'd13; go8 = 1'b1;
    @(posedge clk);
    #1;
    go8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("pre_rst_busy8", {63'd0, busy8}, 64'd1);
    rst = 1'b0;
    #1;
    checkOutput("rst_result8", {56'd0, result8}, 64'd0);
    checkOutput("rst_busy8", {63'd0, busy8}, 64'd0);
    checkOutput("rst_done8", {63'd0, done8}, 64'd0);
    checkOutput("rst_err8", {63'd0, err8}, 64'd0);
    for (int k = 0; k < LAT8 + 2; k++) begin
      @(negedge clk);
      if (k == 2) rst = 1'b1;
      checkOutput("rst_no_done8", {63'd0, done8}, 64'd0);
    end
    applyStimulus8(8'd7, 8'd9, 8'd13);

    // Random WIDTH=8 vectors, biased toward boundary moduli and faults.
    for (int k = 0; k < 400; k++) begin
      rn = 8'($urandom_range(1, 255));
      if (k % 5 == 0)  rn = 8'hFF;
      if (k % 23 == 3) rn = 8'd1;
      ra = 8'($urandom_range(0, 32'(rn) - 1));
      rb = 8'($urandom_range(0, 32'(rn) - 1));
      if (k % 8 == 5)   begin ra = rn - 8'd1; rb = rn - 8'd1; end
      if (k % 16 == 7)  ra = rn;
      if (k % 32 == 11) rn = 8'd0;
      applyStimulus8(ra, rb, rn);
    end

    // WIDTH=32 directed and random vectors.
    applyStimulus32(32'd7, 32'd9, 32'd13);
    applyStimulus32(32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFE);
    applyStimulus32(32'd5, 32'd6, 32'd0);
    for (int k = 0; k < 150; k++) begin
      xn = $urandom;
      if (k % 3 == 0) xn[31] = 1'b1;
      if (xn == 32'd0) xn = 32'd1;
      xa = $urandom;
      xb = $urandom;
      xa = xa % xn;
      xb = xb % xn;
      if (k % 10 == 4) xb = xn;
      applyStimulus32(xa, xb, xn);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
